receiver_mpi_buffer: RTL and testbench

- Credit-based receive stage directly downstream of the MPI sender.
- Accepts 64-bit flits on a valid/data link and stores them in a DEPTH-entry FIFO.
- Returns one yummy (credit) pulse per flit drained by the local consumer.
- Checks the incoming flit stream against an incrementing-sequence expectation and flags overflow and sequence errors.

---
 rtl/receiver_mpi_buffer_if.sv | 28 ++
 rtl/receiver_mpi_buffer.sv | 100 ++++++++++
 tb/tb_receiver_mpi_buffer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/receiver_mpi_buffer_if.sv
// Link bundle between the MPI sender/consumer side and the credit-based receive buffer.
// Signal names keep their original _i/_o suffixes as seen from the buffer.
interface receiver_mpi_buffer_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          valid_i;
  logic [63:0]   data_i;
  logic          yummy_o;
  logic          valid_o;
  logic [63:0]   data_o;
  logic          ready_i;
  logic [CW-1:0] count_o;
  logic          overflow_o;
  logic          mismatch_o;
  logic [15:0]   err_cnt_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output yummy_o, valid_o, data_o, count_o, overflow_o, mismatch_o, err_cnt_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  yummy_o, valid_o, data_o, count_o, overflow_o, mismatch_o, err_cnt_o
  );
endinterface

// File: rtl/receiver_mpi_buffer.sv
// Credit-based receive FIFO: stores sender flits, returns one yummy per drained entry,
// and checks the flit stream against an incrementing sequence starting at SEED.
module receiver_mpi_buffer #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [63:0] SEED     = 64'hcafe_cafe_cafe_cafe,
  parameter bit          CHECK_EN = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  receiver_mpi_buffer_if.slave mpi
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_yummy;
  logic          r_overflow;
  logic          r_mismatch;
  logic [15:0]   r_err_cnt;
  logic [63:0]   r_expected;

  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_count_nxt;

  // A full buffer still accepts a flit when the head leaves in the same cycle.
  assign w_pop  = (r_count != '0) && mpi.ready_i;
  assign w_push = mpi.valid_i && ((r_count < CW'(DEPTH)) || w_pop);
  assign w_drop = mpi.valid_i && !w_push;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= mpi.data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_yummy    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_yummy <= w_pop;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Expected value always resyncs to the accepted flit, so one bad flit is one error.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_expected <= SEED;
      r_mismatch <= 1'b0;
      r_err_cnt  <= '0;
    end else if (CHECK_EN && w_push) begin
      r_expected <= mpi.data_i + 64'd1;
      if (mpi.data_i != r_expected) begin
        r_mismatch <= 1'b1;
        if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
      end
    end
  end

  assign mpi.valid_o    = (r_count != '0);
  assign mpi.data_o     = r_mem[r_rd_ptr];
  assign mpi.count_o    = r_count;
  assign mpi.yummy_o    = r_yummy;
  assign mpi.overflow_o = r_overflow;
  assign mpi.mismatch_o = r_mismatch;
  assign mpi.err_cnt_o  = r_err_cnt;
endmodule

// File: tb/tb_receiver_mpi_buffer.sv
// Self-checking bench for receiver_mpi_buffer: queue-based reference model, per-cycle
// compare, directed scenarios with literal expectations, then randomized traffic.
module tb_receiver_mpi_buffer;
  localparam int unsigned DEPTH = 8;
  localparam logic [63:0] SEED  = 64'hcafe_cafe_cafe_cafe;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  receiver_mpi_buffer_if #(.DEPTH(DEPTH)) bus ();

  receiver_mpi_buffer #(
    .DEPTH   (DEPTH),
    .SEED    (SEED),
    .CHECK_EN(1'b1)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .mpi   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored flits plus the checker state.
  logic [63:0] mq[$];
  logic [63:0] m_exp = SEED;
  bit          m_ovf = 0, m_mis = 0, m_yummy = 0, m_live = 0;
  int          m_err = 0;
  bit          m_pop, m_push;

  always @(posedge clk) begin
    if (!rstn) begin
      mq.delete();
      m_exp = SEED; m_ovf = 0; m_mis = 0; m_err = 0; m_yummy = 0; m_live = 1;
    end else if (m_live) begin
      m_pop  = (mq.size() != 0) && bus.ready_i;
      m_push = bus.valid_i && ((mq.size() < DEPTH) || m_pop);
      m_yummy = m_pop;
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (bus.data_i != m_exp) begin
          m_mis = 1;
          if (m_err < 65535) m_err++;
        end
        m_exp = bus.data_i + 64'd1;
        mq.push_back(bus.data_i);
      end else if (bus.valid_i) begin
        m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("count",    64'(bus.count_o),  64'(mq.size()));
      chk("valid",    64'(bus.valid_o),  64'(mq.size() != 0));
      chk("yummy",    64'(bus.yummy_o),  64'(m_yummy));
      chk("overflow", 64'(bus.overflow_o), 64'(m_ovf));
      chk("mismatch", 64'(bus.mismatch_o), 64'(m_mis));
      chk("err_cnt",  64'(bus.err_cnt_o),  64'(m_err));
      if (mq.size() != 0) chk("data", bus.data_o, mq[0]);
    end
  end

  int ycnt   = 0;
  int maxcnt = 0;

  task automatic cyc(input bit v, input logic [63:0] d, input bit r);
    bus.valid_i = v;
    bus.data_i  = d;
    bus.ready_i = r;
    @(posedge clk);
    @(negedge clk);
    ycnt += int'(bus.yummy_o);
    if (int'(bus.count_o) > maxcnt) maxcnt = int'(bus.count_o);
  endtask

  task automatic rst_cyc(input bit r);
    rstn = 1'b0;
    cyc(1'b0, '0, r);
    rstn = 1'b1;
  endtask

  logic [63:0] last;
  bit          rv, rr;
  logic [63:0] rd;

  initial begin
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.ready_i = 1'b0;
    rst_cyc(1'b0);
    rst_cyc(1'b0);
    chk("rst_count", 64'(bus.count_o), 64'd0);
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_data",  bus.data_o, 64'd0);
    chk("rst_yummy", 64'(bus.yummy_o), 64'd0);

    // Seven in-sequence flits with consumer stalled
    for (int i = 0; i < 7; i++) cyc(1'b1, SEED + 64'(i), 1'b0);
    chk("s1_count", 64'(bus.count_o), 64'd7);
    chk("s1_valid", 64'(bus.valid_o), 64'd1);
    chk("s1_data",  bus.data_o, 64'hcafe_cafe_cafe_cafe);
    chk("s1_yummy", 64'(bus.yummy_o), 64'd0);
    chk("s1_mis",   64'(bus.mismatch_o), 64'd0);

    // Drain: yummies lag pops by one cycle
    ycnt = 0;
    for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b1);
    chk("s2_yummy_last", 64'(bus.yummy_o), 64'd1);
    cyc(1'b0, '0, 1'b1);
    chk("s2_ycnt",  64'(ycnt), 64'd7);
    chk("s2_count", 64'(bus.count_o), 64'd0);
    chk("s2_valid", 64'(bus.valid_o), 64'd0);

    // Fill to DEPTH, drop one, then push-with-pop when full
    for (int i = 7; i < 15; i++) cyc(1'b1, SEED + 64'(i), 1'b0);
    chk("s3_full", 64'(bus.count_o), 64'd8);
    cyc(1'b1, SEED + 64'd15, 1'b0);
    chk("s3_drop_cnt", 64'(bus.count_o), 64'd8);
    chk("s3_ovf",      64'(bus.overflow_o), 64'd1);
    cyc(1'b1, SEED + 64'd15, 1'b1);
    chk("s3_pp_cnt", 64'(bus.count_o), 64'd8);
    chk("s3_pp_ovf", 64'(bus.overflow_o), 64'd1);
    chk("s3_mis",    64'(bus.mismatch_o), 64'd0);
    chk("s3_head",   bus.data_o, SEED + 64'd8);
    for (int i = 0; i < 9; i++) cyc(1'b0, '0, 1'b1);

    // Single bad flit counts once and resyncs
    rst_cyc(1'b0);
    cyc(1'b1, SEED, 1'b1);
    cyc(1'b1, 64'h1234, 1'b1);
    cyc(1'b1, 64'h1235, 1'b1);
    chk("s4_err", 64'(bus.err_cnt_o), 64'd1);
    chk("s4_mis", 64'(bus.mismatch_o), 64'd1);
    cyc(1'b1, 64'h1236, 1'b1);
    chk("s4_err2", 64'(bus.err_cnt_o), 64'd1);
    cyc(1'b0, '0, 1'b1);

    // Continuous stream with consumer always ready
    ycnt = 0; maxcnt = 0;
    for (int i = 0; i < 20; i++) cyc(1'b1, 64'h1237 + 64'(i), 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    chk("s5_ycnt",   64'(ycnt), 64'd20);
    chk("s5_maxcnt", 64'(maxcnt <= 1), 64'd1);
    chk("s5_err",    64'(bus.err_cnt_o), 64'd1);

    // Reset mid-operation with 5 stored flits
    for (int i = 0; i < 5; i++) cyc(1'b1, 64'h124b + 64'(i), 1'b0);
    chk("s6_pre", 64'(bus.count_o), 64'd5);
    rst_cyc(1'b1);
    chk("s6_count", 64'(bus.count_o), 64'd0);
    chk("s6_valid", 64'(bus.valid_o), 64'd0);
    chk("s6_yummy", 64'(bus.yummy_o), 64'd0);
    chk("s6_mis",   64'(bus.mismatch_o), 64'd0);
    chk("s6_err",   64'(bus.err_cnt_o), 64'd0);
    cyc(1'b1, SEED, 1'b0);
    chk("s6_seed_err", 64'(bus.err_cnt_o), 64'd0);
    cyc(1'b0, '0, 1'b1);

    // All-ones followed by zero is in sequence
    cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    chk("s7_err1", 64'(bus.err_cnt_o), 64'd1);
    cyc(1'b1, 64'h0, 1'b1);
    chk("s7_err2", 64'(bus.err_cnt_o), 64'd1);
    cyc(1'b0, '0, 1'b1);

    // Randomized traffic against the model
    last = 64'h1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) == 0) begin
        rst_cyc(1'($urandom_range(1)));
        last = SEED - 64'd1;
      end else begin
        rv = ($urandom_range(3) != 0);
        rr = ((i / 60) % 2 == 1) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
        case ($urandom_range(15))
          0:       rd = {$urandom, $urandom};
          1:       rd = 64'hFFFF_FFFF_FFFF_FFFE;
          default: rd = last + 64'd1;
        endcase
        if (rv) last = rd;
        cyc(rv, rd, rr);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
